spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 8: bits per received word; SHALL be at least 2.
REQ-002 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 sclk  input  1  SPI serial clock from the master; idles low; asynchronous to clk.
REQ-005 cs  input  1  SPI chip select, active-low; asynchronous to clk.
REQ-006 mosi  input  1  SPI serial data, MSB first; asynchronous to clk.
REQ-007 rx_ready  input  1  downstream consumer accepts rx_data while rx_valid=1.
REQ-008 rx_data  output  DATA_W  received word; held stable while rx_valid=1.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 overrun  output  1  single-cycle pulse: a completed word was dropped because the output register was full.
REQ-011 frame_err  output  1  single-cycle pulse: cs deasserted mid-word.
REQ-012 busy  output  1  high while the FSM is in SHIFT.

Function
REQ-013 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer (s1, s2); cs and mosi synchronizers SHALL reset to 1 and 0 respectively; sclk to 0.
REQ-014 A rising-edge detect flop SHALL hold the previous s2 of sclk; an edge SHALL be detected in a cycle where sclk_s2=1 and sclk_prev=0.
REQ-015 The master SHALL keep sclk high and low for at least 3 clk cycles each; shorter phases are unsupported.
REQ-016 The FSM SHALL have two states, IDLE and SHIFT, and SHALL reset to IDLE.
REQ-017 IDLE -> SHIFT when cs_s2=0; bit counter and shift register SHALL be cleared on entry.
REQ-018 In SHIFT, on each detected sclk rising edge, mosi_s2 SHALL shift into the shift register LSB, existing bits moving toward the MSB, and the bit counter SHALL increment.
REQ-019 On the edge that completes bit DATA_W, the word SHALL be complete; the counter SHALL wrap to 0 and the FSM SHALL stay in SHIFT so back-to-back words within one cs-low window are received.
REQ-020 A completed word SHALL be loaded into rx_data with rx_valid=1 on the next clk edge if rx_valid=0, or if rx_valid=1 and rx_ready=1 in the same cycle.
REQ-021 If rx_valid=1 and rx_ready=0 when a word completes, the new word SHALL be dropped, rx_data SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-022 A transfer SHALL occur in a cycle where rx_valid=1 and rx_ready=1; rx_valid SHALL clear on the next edge unless a new word loads in that same cycle (REQ-020).
REQ-023 SHIFT -> IDLE when cs_s2=1; if the bit counter is nonzero, frame_err SHALL pulse for one cycle and the partial word SHALL be discarded.
REQ-024 If cs_s2 rises in the same cycle as the completing sclk edge, the word SHALL complete and frame_err SHALL NOT pulse.
REQ-025 sclk edges while in IDLE SHALL be ignored.
REQ-026 Latency: rx_valid SHALL rise 4 clk cycles after the completing sclk rising edge at the pin (2 sync + 1 detect + 1 output register).

Reset
REQ-027 On rst=0, asynchronously: FSM=IDLE; counter, shift register and rx_data=0; rx_valid=0, overrun=0, frame_err=0, busy=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word without a frame_err pulse; after release, reception SHALL restart only after cs_s2 is seen high then low.

Verification
REQ-029 cs low, 8 sclk pulses (4 clk high, 4 clk low), mosi=0xEF MSB first, rx_ready=1 -> rx_data=0xEF, rx_valid high 1 cycle, no overrun or frame_err.
REQ-030 Two words 0xA5 then 0x3C in one cs-low window, rx_ready=0 -> rx_data=0xA5 retained, overrun pulses once; then rx_ready=1 -> rx_valid clears.
REQ-031 cs low, 5 bits, cs high -> frame_err pulses once, rx_valid stays 0, busy falls.
REQ-032 sclk toggles 8 times with cs high -> no rx_valid, busy=0.
REQ-033 rst asserted after 4 bits of 0xFF, released, then a full 0x81 frame -> rx_data=0x81, no frame_err.
REQ-034 Last sclk edge and cs deassertion in the same synchronized cycle -> word delivered, frame_err=0.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (mode 0, MSB first): synchronizes the SPI pins into clk,
// deserializes DATA_W-bit words and hands them out through a valid/ready register.
module spi_slave_rx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic sclk_s1, sclk_s2, sclk_prev;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic sclk_rise_c;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic              word_done_q;

    logic shift_en_c, word_done_c, frame_err_c, clear_c;

    // Pin synchronizers; cs idles deasserted so reset lands it high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
            mosi_s1   <= mosi;
            mosi_s2   <= mosi_s1;
        end
    end

    assign sclk_rise_c = sclk_s2 & ~sclk_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_s2) state_d = SHIFT;
            SHIFT:   if (cs_s2)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A completing edge coincident with cs release still counts as a full word
    always_comb begin
        shift_en_c  = 1'b0;
        word_done_c = 1'b0;
        frame_err_c = 1'b0;
        clear_c     = 1'b0;
        case (state_q)
            IDLE: begin
                clear_c = 1'b1;
            end
            SHIFT: begin
                shift_en_c  = sclk_rise_c;
                word_done_c = sclk_rise_c && (cnt_q == LAST_BIT);
                frame_err_c = cs_s2 && (cnt_q != '0) && !word_done_c;
            end
            default: begin
                clear_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= word_done_c;
            if (clear_c) begin
                cnt_q   <= '0;
                shreg_q <= '0;
            end else if (shift_en_c) begin
                shreg_q <= {shreg_q[DATA_W-2:0], mosi_s2};
                cnt_q   <= word_done_c ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    // Output register: a full register with no consumer drops the new word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            overrun   <= word_done_q && rx_valid && !rx_ready;
            frame_err <= frame_err_c;
            busy      <= (state_d == SHIFT);
            if (word_done_q && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of single-word frames plus hand-written
// sequences for overrun, frame error, idle clocks, mid-word reset and cs/sclk coincidence.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Event monitor: counts valid rises, valid-high cycles and error pulses
    int         n_rise = 0;
    int         n_vcyc = 0;
    int         n_ov   = 0;
    int         n_fe   = 0;
    logic [7:0] last_word = 8'h00;
    logic       v_d = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && !v_d) begin
            n_rise    = n_rise + 1;
            last_word = rx_data;
        end
        if (rx_valid)  n_vcyc = n_vcyc + 1;
        if (overrun)   n_ov   = n_ov + 1;
        if (frame_err) n_fe   = n_fe + 1;
        v_d = rx_valid;
    end

    int r0, c0, o0, f0;

    task automatic snap();
        r0 = n_rise;
        c0 = n_vcyc;
        o0 = n_ov;
        f0 = n_fe;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 4 clk high, 4 clk low; mosi settles before the rising edge
    task automatic send_bit(input logic b);
        mosi = b;
        cycles(2);
        sclk = 1'b1;
        cycles(4);
        sclk = 1'b0;
        cycles(2);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic frame(input logic [7:0] w);
        cs = 1'b0;
        cycles(4);
        send_word(w);
        cycles(2);
        cs = 1'b1;
        cycles(8);
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_data;
        int         exp_rise;
        int         exp_vcyc;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat;
        logic [7:0] w;

        vecs[0] = '{word: 8'hEF, exp_data: 8'hEF, exp_rise: 1, exp_vcyc: 1};
        vecs[1] = '{word: 8'h00, exp_data: 8'h00, exp_rise: 1, exp_vcyc: 1};
        vecs[2] = '{word: 8'hFF, exp_data: 8'hFF, exp_rise: 1, exp_vcyc: 1};
        vecs[3] = '{word: 8'h5A, exp_data: 8'h5A, exp_rise: 1, exp_vcyc: 1};
        vecs[4] = '{word: 8'h01, exp_data: 8'h01, exp_rise: 1, exp_vcyc: 1};

        // Reset state
        cycles(3);
        chk("rst_rx_valid",  int'(rx_valid),  0);
        chk("rst_rx_data",   int'(rx_data),   0);
        chk("rst_overrun",   int'(overrun),   0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_busy",      int'(busy),      0);
        rst = 1'b1;
        cycles(4);
        chk("post_rst_busy", int'(busy), 0);

        // Single-word frames, consumer always ready
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            snap();
            frame(vecs[i].word);
            chk($sformatf("vec%0d_data", i),  int'(last_word), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_rise", i),  n_rise - r0, vecs[i].exp_rise);
            chk($sformatf("vec%0d_vcyc", i),  n_vcyc - c0, vecs[i].exp_vcyc);
            chk($sformatf("vec%0d_ov", i),    n_ov - o0, 0);
            chk($sformatf("vec%0d_fe", i),    n_fe - f0, 0);
            chk($sformatf("vec%0d_busy", i),  int'(busy), 0);
        end

        // Two words back-to-back with consumer stalled: second word is dropped
        snap();
        rx_ready = 1'b0;
        cs = 1'b0;
        cycles(4);
        send_word(8'hA5);
        send_word(8'h3C);
        cycles(2);
        cs = 1'b1;
        cycles(8);
        chk("ovr_rx_data",  int'(rx_data),  8'hA5);
        chk("ovr_rx_valid", int'(rx_valid), 1);
        chk("ovr_pulses",   n_ov - o0, 1);
        chk("ovr_rise",     n_rise - r0, 1);
        chk("ovr_fe",       n_fe - f0, 0);
        rx_ready = 1'b1;
        cycles(1);
        chk("ovr_drain_valid", int'(rx_valid), 0);
        cycles(2);

        // Partial word then cs release
        snap();
        cs = 1'b0;
        cycles(4);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("ferr_busy_mid", int'(busy), 1);
        cs = 1'b1;
        cycles(8);
        chk("ferr_pulses", n_fe - f0, 1);
        chk("ferr_rise",   n_rise - r0, 0);
        chk("ferr_busy",   int'(busy), 0);
        chk("ferr_valid",  int'(rx_valid), 0);

        // sclk activity with cs deasserted
        snap();
        send_word(8'hFF);
        cycles(4);
        chk("idle_rise", n_rise - r0, 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_fe",   n_fe - f0, 0);

        // Reset mid-word, then a clean frame
        snap();
        cs = 1'b0;
        cycles(4);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b0;
        cycles(1);
        chk("midrst_busy",  int'(busy), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        cycles(2);
        cs = 1'b1;
        rst = 1'b1;
        cycles(4);
        frame(8'h81);
        chk("midrst_data", int'(last_word), 8'h81);
        chk("midrst_rx_data", int'(rx_data), 8'h81);
        chk("midrst_rise", n_rise - r0, 1);
        chk("midrst_fe",   n_fe - f0, 0);

        // Last sclk edge and cs release together; also measures pin-to-valid latency
        snap();
        w = 8'hC3;
        cs = 1'b0;
        cycles(4);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        mosi = w[0];
        cycles(2);
        sclk = 1'b1;
        cs = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            lat = lat + 1;
            @(negedge clk);
            if (rx_valid) break;
        end
        chk("coinc_latency", lat, 4);
        cycles(3);
        sclk = 1'b0;
        cycles(8);
        chk("coinc_data", int'(last_word), 8'hC3);
        chk("coinc_rise", n_rise - r0, 1);
        chk("coinc_fe",   n_fe - f0, 0);
        chk("coinc_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
